// File: rtl/potential_adder_array.sv
// Time-multiplexed leaky integrate-and-fire update engine: accumulates weighted input
// events per neuron while idle, then sweeps every neuron once per timestep.
module potential_adder_array #(
   parameter int NUM_NEURONS = 32,
   parameter int DATA_W      = 32,
   parameter int FRAC_W      = 16,
   parameter int ID_W        = $clog2(NUM_NEURONS),
   parameter int REFR_W      = 4,
   parameter logic signed [DATA_W-1:0] V_TH_DEFAULT = DATA_W'(40) << FRAC_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              cfg_load,
   input  logic [DATA_W-1:0] cfg_v_threshold,
   input  logic              cfg_reset_mode,
   input  logic [4:0]        cfg_leak_shift,
   input  logic [REFR_W-1:0] cfg_refractory,
   input  logic              acc_valid,
   output logic              acc_ready,
   input  logic [ID_W-1:0]   acc_neuron_id,
   input  logic [DATA_W-1:0] acc_weight,
   input  logic              timestep_start,
   output logic              spike_valid,
   output logic [ID_W-1:0]   spike_neuron_id,
   output logic [DATA_W-1:0] final_potential,
   output logic              done,
   output logic              busy,
   output logic              err_overrun,
   output logic              err_bad_id
);

   localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int EXT_W = DATA_W + 2;
   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [ID_W:0]    NUM_ID   = (ID_W+1)'(NUM_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t                   r_state;
   logic [IDX_W-1:0]         r_idx;
   logic signed [DATA_W-1:0] r_v   [NUM_NEURONS];
   logic signed [DATA_W-1:0] r_acc [NUM_NEURONS];
   logic [REFR_W-1:0]        r_refr [NUM_NEURONS];

   logic signed [DATA_W-1:0] r_th;
   logic                     r_mode;
   logic [4:0]               r_shift;
   logic [REFR_W-1:0]        r_refr_cfg;

   logic                     r_spike_valid;
   logic [ID_W-1:0]          r_spike_id;
   logic signed [DATA_W-1:0] r_final;
   logic                     r_done;
   logic                     r_err_overrun;
   logic                     r_err_bad_id;

   // Widened arithmetic is clamped back to DATA_W; values never wrap.
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] x);
      logic signed [DATA_W-1:0] y;
      if (x > EXT_W'(SAT_MAX))
         y = SAT_MAX;
      else if (x < EXT_W'(SAT_MIN))
         y = SAT_MIN;
      else
         y = x[DATA_W-1:0];
      return y;
   endfunction

   logic                     w_id_ok;
   logic [IDX_W-1:0]         w_acc_idx;
   logic signed [DATA_W-1:0] w_acc_sum;
   logic signed [DATA_W-1:0] w_v_cur;
   logic signed [DATA_W-1:0] w_leak;
   logic signed [DATA_W-1:0] w_t;
   logic                     w_in_refr;
   logic                     w_fire;
   logic signed [DATA_W-1:0] w_v_fire;
   logic signed [DATA_W-1:0] w_v_new;

   always_comb begin
      w_id_ok   = ({1'b0, acc_neuron_id} < NUM_ID);
      w_acc_idx = acc_neuron_id[IDX_W-1:0];
      w_acc_sum = sat(EXT_W'(r_acc[w_acc_idx]) + EXT_W'(signed'(acc_weight)));

      // A shift of zero means no leak rather than v - v.
      w_v_cur   = r_v[r_idx];
      w_leak    = (r_shift == 5'd0) ? '0 : (w_v_cur >>> r_shift);
      w_t       = sat(EXT_W'(w_v_cur) - EXT_W'(w_leak) + EXT_W'(r_acc[r_idx]));
      w_in_refr = (r_refr[r_idx] != '0);
      w_fire    = !w_in_refr && (w_t >= r_th);
      w_v_fire  = r_mode ? '0 : sat(EXT_W'(w_t) - EXT_W'(r_th));
      w_v_new   = w_in_refr ? '0 : (w_fire ? w_v_fire : w_t);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_th          <= V_TH_DEFAULT;
         r_mode        <= 1'b0;
         r_shift       <= '0;
         r_refr_cfg    <= '0;
         r_spike_valid <= 1'b0;
         r_spike_id    <= '0;
         r_final       <= '0;
         r_done        <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_bad_id  <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_v[i]    <= '0;
            r_acc[i]  <= '0;
            r_refr[i] <= '0;
         end
      end else begin
         r_spike_valid <= 1'b0;
         r_done        <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_load) begin
                  r_th       <= cfg_v_threshold;
                  r_mode     <= cfg_reset_mode;
                  r_shift    <= cfg_leak_shift;
                  r_refr_cfg <= cfg_refractory;
               end
               if (acc_valid) begin
                  if (w_id_ok)
                     r_acc[w_acc_idx] <= w_acc_sum;
                  else
                     r_err_bad_id <= 1'b1;
               end
               if (timestep_start) begin
                  r_state <= S_SCAN;
                  r_idx   <= '0;
               end
            end
            S_SCAN: begin
               if (timestep_start)
                  r_err_overrun <= 1'b1;
               r_v[r_idx]   <= w_v_new;
               r_acc[r_idx] <= '0;
               if (w_in_refr)
                  r_refr[r_idx] <= r_refr[r_idx] - 1'b1;
               else if (w_fire)
                  r_refr[r_idx] <= r_refr_cfg;
               r_spike_valid <= w_fire;
               r_spike_id    <= ID_W'(r_idx);
               r_final       <= w_v_new;
               if (r_idx == LAST_IDX) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign acc_ready       = (r_state == S_IDLE);
   assign busy            = (r_state == S_SCAN);
   assign spike_valid     = r_spike_valid;
   assign spike_neuron_id = r_spike_id;
   assign final_potential = r_final;
   assign done            = r_done;
   assign err_overrun     = r_err_overrun;
   assign err_bad_id      = r_err_bad_id;

endmodule

// File: tb/tb_potential_adder_array.sv
// Directed bench for potential_adder_array (32 neurons, Q8.8 16-bit potentials, ID_W=6).
module tb_potential_adder_array;

   localparam int N = 32;

   logic        CLK;
   logic        RESET;
   logic        cfg_load;
   logic [15:0] cfg_v_threshold;
   logic        cfg_reset_mode;
   logic [4:0]  cfg_leak_shift;
   logic [3:0]  cfg_refractory;
   logic        acc_valid;
   logic        acc_ready;
   logic [5:0]  acc_neuron_id;
   logic [15:0] acc_weight;
   logic        timestep_start;
   logic        spike_valid;
   logic [5:0]  spike_neuron_id;
   logic [15:0] final_potential;
   logic        done;
   logic        busy;
   logic        err_overrun;
   logic        err_bad_id;

   potential_adder_array #(
      .NUM_NEURONS(N),
      .DATA_W(16),
      .FRAC_W(8),
      .ID_W(6),
      .REFR_W(4)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .cfg_load(cfg_load),
      .cfg_v_threshold(cfg_v_threshold),
      .cfg_reset_mode(cfg_reset_mode),
      .cfg_leak_shift(cfg_leak_shift),
      .cfg_refractory(cfg_refractory),
      .acc_valid(acc_valid),
      .acc_ready(acc_ready),
      .acc_neuron_id(acc_neuron_id),
      .acc_weight(acc_weight),
      .timestep_start(timestep_start),
      .spike_valid(spike_valid),
      .spike_neuron_id(spike_neuron_id),
      .final_potential(final_potential),
      .done(done),
      .busy(busy),
      .err_overrun(err_overrun),
      .err_bad_id(err_bad_id)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          spk_cnt;
   int          done_cyc;
   int          spk_cyc [N];
   logic [15:0] fp [N];
   logic        busy1, ready1, busy_n, ready_done, busy_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", tag, got);
      end
   endtask

   // Callers sit just after a falling edge; every task returns the same way.
   task automatic send(input logic [5:0] id, input logic [15:0] w);
      acc_valid = 1'b1; acc_neuron_id = id; acc_weight = w;
      @(negedge CLK);
      acc_valid = 1'b0;
   endtask

   task automatic cfg(input logic [15:0] th, input logic mode, input logic [4:0] sh,
                      input logic [3:0] rf);
      cfg_load = 1'b1; cfg_v_threshold = th; cfg_reset_mode = mode;
      cfg_leak_shift = sh; cfg_refractory = rf;
      @(negedge CLK);
      cfg_load = 1'b0;
   endtask

   // Cycle c counts from the cycle after timestep_start is sampled (T0+c).
   task automatic run_step(input int ovr_at, input logic co_en, input logic [5:0] co_id,
                           input logic [15:0] co_w);
      int c;
      spk_cnt  = 0;
      done_cyc = -1;
      for (int i = 0; i < N; i++) begin
         spk_cyc[i] = -1;
         fp[i]      = 16'hDEAD;
      end
      timestep_start = 1'b1;
      acc_valid = co_en; acc_neuron_id = co_id; acc_weight = co_w;
      @(negedge CLK);
      acc_valid = 1'b0;
      c = 1;
      while (done_cyc < 0 && c <= 80) begin
         if (c == 1) begin busy1 = busy; ready1 = acc_ready; end
         if (c == N) busy_n = busy;
         if (c >= 2 && c <= N + 1) fp[c-2] = final_potential;
         if (spike_valid) begin
            spk_cnt++;
            if (spike_neuron_id < 6'(N)) spk_cyc[spike_neuron_id] = c;
         end
         timestep_start = (c == ovr_at);
         if (done) begin
            done_cyc = c; ready_done = acc_ready; busy_done = busy;
         end else begin
            @(negedge CLK);
            c++;
         end
      end
      timestep_start = 1'b0;
   endtask

   initial begin
      int cnt;
      RESET = 1'b1; cfg_load = 1'b0; cfg_v_threshold = '0; cfg_reset_mode = 1'b0;
      cfg_leak_shift = '0; cfg_refractory = '0; acc_valid = 1'b0; acc_neuron_id = '0;
      acc_weight = '0; timestep_start = 1'b0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      chk("rst_ready", acc_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_spike", spike_valid, 0);
      chk("rst_final", final_potential, 0);
      chk("rst_done", done, 0);
      chk("rst_err_ovr", err_overrun, 0);
      chk("rst_err_id", err_bad_id, 0);

      // Abort a sweep with RESET; pending state must vanish.
      send(6'd2, 16'h2000);
      send(6'd20, 16'h3000);
      timestep_start = 1'b1;
      @(negedge CLK);
      timestep_start = 1'b0;
      repeat (9) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      chk("abort_busy", busy, 0);
      @(negedge CLK);
      RESET = 1'b0;
      chk("abort_ready", acc_ready, 1);
      cnt = 0;
      repeat (40) begin
         @(negedge CLK);
         if (done || spike_valid) cnt++;
      end
      chk("abort_no_done", cnt, 0);
      run_step(0, 1'b0, '0, '0);
      chk("rst_spk_cnt", spk_cnt, 0);
      chk("rst_done_cyc", done_cyc, 33);
      cnt = 0;
      for (int i = 0; i < N; i++) if (fp[i] !== 16'h0) cnt++;
      chk("rst_fp_nonzero", cnt, 0);

      // Single spike with default threshold 40.0: 28+16 = 44 -> 4.0.
      send(6'd5, 16'h1C00);
      send(6'd5, 16'h1000);
      run_step(0, 1'b0, '0, '0);
      chk("lif_spk_cyc5", spk_cyc[5], 7);
      chk("lif_fp5", fp[5], 16'h0400);
      chk("lif_spk_cnt", spk_cnt, 1);
      chk("lif_busy1", busy1, 1);
      chk("lif_ready1", ready1, 0);
      chk("lif_busyN", busy_n, 1);
      chk("lif_done_cyc", done_cyc, 33);
      chk("lif_ready_done", ready_done, 1);
      chk("lif_busy_done", busy_done, 0);

      // Leak shift 1, zero-reset: v3 = 32, then 32-16+30 = 46 fires.
      cfg(16'h2800, 1'b1, 5'd1, 4'd0);
      send(6'd3, 16'h2000);
      run_step(0, 1'b0, '0, '0);
      chk("leak_fp3_a", fp[3], 16'h2000);
      chk("leak_fp5_a", fp[5], 16'h0200);
      send(6'd3, 16'h1E00);
      run_step(0, 1'b0, '0, '0);
      chk("leak_spk_cyc3", spk_cyc[3], 5);
      chk("leak_fp3_b", fp[3], 16'h0000);
      chk("leak_fp5_b", fp[5], 16'h0100);
      chk("leak_spk_cnt", spk_cnt, 1);

      // Refractory 2: 48.0 each step fires in steps 1 and 4 only.
      cfg(16'h2800, 1'b0, 5'd0, 4'd2);
      for (int s = 1; s <= 4; s++) begin
         send(6'd0, 16'h3000);
         run_step(0, 1'b0, '0, '0);
         chk($sformatf("refr_spk0_s%0d", s), spk_cyc[0], (s == 1 || s == 4) ? 2 : -1);
         chk($sformatf("refr_fp0_s%0d", s), fp[0], (s == 1 || s == 4) ? 16'h0800 : 16'h0000);
      end

      // Saturating accumulator: 0x7F00 + 0x7F00 clamps positive and fires.
      cfg(16'h2800, 1'b1, 5'd0, 4'd0);
      send(6'd1, 16'h7F00);
      send(6'd1, 16'h7F00);
      run_step(0, 1'b0, '0, '0);
      chk("sat_spk_cyc1", spk_cyc[1], 3);
      chk("sat_fp1", fp[1], 16'h0000);
      chk("sat_spk_cnt", spk_cnt, 1);

      // Event coincident with timestep_start counts: 16 + 32 = 48 -> 8.0.
      cfg(16'h2800, 1'b0, 5'd0, 4'd0);
      send(6'd7, 16'h1000);
      run_step(0, 1'b1, 6'd7, 16'h2000);
      chk("coll_spk_cyc7", spk_cyc[7], 9);
      chk("coll_fp7", fp[7], 16'h0800);

      // timestep_start mid-sweep: flagged, sweep length unchanged, no re-scan.
      run_step(10, 1'b0, '0, '0);
      chk("ovr_done_cyc", done_cyc, 33);
      chk("ovr_flag", err_overrun, 1);
      chk("ovr_spk_cnt", spk_cnt, 0);
      chk("ovr_fp7", fp[7], 16'h0800);
      @(negedge CLK);
      chk("ovr_no_rescan", busy, 0);

      // Out-of-range id is dropped and must not alias onto neuron 8.
      send(6'd40, 16'h7000);
      chk("badid_flag", err_bad_id, 1);
      run_step(0, 1'b0, '0, '0);
      chk("badid_spk_cnt", spk_cnt, 0);
      chk("badid_fp8", fp[8], 16'h0000);
      chk("badid_fp5", fp[5], 16'h0100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
